video_signal_generator: RTL and testbench



---
 rtl/video_timing_pkg.sv | 46 ++++
 rtl/video_axis_timer.sv | 65 ++++++
 rtl/video_signal_generator.sv | 118 +++++++++++
 tb/tb_video_signal_generator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
//
// Purpose: shared raster-timing constants and small helpers for the video
// pipeline. It holds the 720p60 (CEA-861) defaults, a helper that sums the
// four segment lengths of an axis, and a helper that sizes a counter.
//
// Contents:
//   DEF_*         default segment lengths for 1280x720 @ 60 Hz
//   DEF_TOTAL_H   pixels per line in the default mode (1650)
//   DEF_TOTAL_V   lines per frame in the default mode (750)
//   axis_total()  active + front porch + sync + back porch
//   cnt_width()   bits needed to hold 0..n-1 (at least 1)
// ---------------------------------------------------------------------------
package video_timing_pkg;

    localparam int DEF_ACTIVE_H_PIXELS = 1280;
    localparam int DEF_H_FRONT_PORCH   = 110;
    localparam int DEF_H_SYNCH_WIDTH   = 40;
    localparam int DEF_H_BACK_PORCH    = 220;

    localparam int DEF_ACTIVE_LINES    = 720;
    localparam int DEF_V_FRONT_PORCH   = 5;
    localparam int DEF_V_SYNCH_WIDTH   = 5;
    localparam int DEF_V_BACK_PORCH    = 20;

    localparam int DEF_FPS             = 60;

    // Full length of one axis, in pixels (H) or lines (V).
    function automatic int axis_total(input int active, input int front_porch,
                                      input int sync_width, input int back_porch);
        return active + front_porch + sync_width + back_porch;
    endfunction

    // Width of a counter that runs 0..n-1. Kept at one bit minimum so a
    // degenerate modulus of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_TOTAL_H = axis_total(DEF_ACTIVE_H_PIXELS, DEF_H_FRONT_PORCH,
                                            DEF_H_SYNCH_WIDTH, DEF_H_BACK_PORCH);
    localparam int DEF_TOTAL_V = axis_total(DEF_ACTIVE_LINES, DEF_V_FRONT_PORCH,
                                            DEF_V_SYNCH_WIDTH, DEF_V_BACK_PORCH);

endpackage

// File: rtl/video_axis_timer.sv
// ---------------------------------------------------------------------------
// video_axis_timer
//
// Purpose: one axis (horizontal or vertical) of the raster timing. A position
// counter that advances when enabled and wraps at the end of the axis, plus
// combinational decodes of the active region and the sync pulse.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset, forces pos to 0
//   en      in   advance the position this cycle
//   pos     out  current position, 0..TOTAL-1
//   wrap    out  high when en is set and pos is at TOTAL-1 (next edge -> 0)
//   active  out  pos < ACTIVE
//   sync    out  ACTIVE+FRONT_PORCH <= pos < ACTIVE+FRONT_PORCH+SYNC_WIDTH
// ---------------------------------------------------------------------------
module video_axis_timer
    import video_timing_pkg::*;
#(
    parameter int ACTIVE      = DEF_ACTIVE_H_PIXELS,
    parameter int FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int SYNC_WIDTH  = DEF_H_SYNCH_WIDTH,
    parameter int BACK_PORCH  = DEF_H_BACK_PORCH,
    localparam int TOTAL      = axis_total(ACTIVE, FRONT_PORCH, SYNC_WIDTH, BACK_PORCH),
    localparam int W          = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    // Region boundaries carry one extra bit: a window that ends exactly at
    // TOTAL (zero back porch, or no blanking at all) would otherwise alias
    // to 0 when TOTAL is a power of two.
    localparam logic [W:0] ACTIVE_END = (W + 1)'(ACTIVE);
    localparam logic [W:0] SYNC_START = (W + 1)'(ACTIVE + FRONT_PORCH);
    localparam logic [W:0] SYNC_END   = (W + 1)'(ACTIVE + FRONT_PORCH + SYNC_WIDTH);

    logic [W:0] pos_ext;

    assign pos_ext = {1'b0, pos};
    assign wrap    = en && (pos == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (en) begin
            if (wrap) begin
                pos <= '0;
            end else begin
                pos <= pos + 1'b1;
            end
        end
    end

    assign active = (pos_ext < ACTIVE_END);
    assign sync   = (pos_ext >= SYNC_START) && (pos_ext < SYNC_END);

endmodule

// File: rtl/video_signal_generator.sv
// ---------------------------------------------------------------------------
// video_signal_generator
//
// Purpose: pixel-clock raster timing generator. Produces the screen position,
// active-high sync pulses, data enable, a new-frame strobe and a frame
// counter modulo FPS. Defaults give 1280x720 @ 60 Hz.
//
// There is no handshake: every output is valid on every cycle and all of
// them describe the pixel at (o_sx, o_sy). Syncs, DE and NF are decoded
// combinationally from the registered counters, so they carry no extra
// latency relative to the position.
//
// Ports:
//   i_clk_pxl  in   pixel clock
//   i_reset    in   asynchronous active-high reset; position and frame
//                   counter go to 0 immediately
//   o_sx       out  horizontal position, 0..TOTAL_H-1
//   o_sy       out  vertical position, 0..TOTAL_V-1
//   o_hsync    out  horizontal sync, active-high
//   o_vsync    out  vertical sync, active-high (whole lines)
//   o_de       out  data enable, high inside the active area
//   o_nf       out  new-frame strobe, high at (0,0)
//   o_fc       out  frame counter, 0..FPS-1
// ---------------------------------------------------------------------------
module video_signal_generator
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
    parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
    parameter int H_SYNCH_WIDTH   = DEF_H_SYNCH_WIDTH,
    parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
    parameter int V_SYNCH_WIDTH   = DEF_V_SYNCH_WIDTH,
    parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
    parameter int FPS             = DEF_FPS,
    localparam int TOTAL_H = axis_total(ACTIVE_H_PIXELS, H_FRONT_PORCH,
                                        H_SYNCH_WIDTH, H_BACK_PORCH),
    localparam int TOTAL_V = axis_total(ACTIVE_LINES, V_FRONT_PORCH,
                                        V_SYNCH_WIDTH, V_BACK_PORCH),
    localparam int H_W     = cnt_width(TOTAL_H),
    localparam int V_W     = cnt_width(TOTAL_V),
    localparam int FC_W    = cnt_width(FPS)
) (
    input  logic            i_clk_pxl,
    input  logic            i_reset,
    output logic [H_W-1:0]  o_sx,
    output logic [V_W-1:0]  o_sy,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_de,
    output logic            o_nf,
    output logic [FC_W-1:0] o_fc
);

    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FPS - 1);

    logic h_wrap;
    logic h_active;
    logic h_sync;
    logic v_wrap;
    logic v_active;
    logic v_sync;

    logic [FC_W-1:0] fc;

    // Horizontal axis advances every pixel clock.
    video_axis_timer #(
        .ACTIVE      (ACTIVE_H_PIXELS),
        .FRONT_PORCH (H_FRONT_PORCH),
        .SYNC_WIDTH  (H_SYNCH_WIDTH),
        .BACK_PORCH  (H_BACK_PORCH)
    ) u_h_timer (
        .clk    (i_clk_pxl),
        .rst    (i_reset),
        .en     (1'b1),
        .pos    (o_sx),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    // Vertical axis advances once per line, on the last pixel of the line.
    // Its wrap flag is therefore the end-of-frame condition.
    video_axis_timer #(
        .ACTIVE      (ACTIVE_LINES),
        .FRONT_PORCH (V_FRONT_PORCH),
        .SYNC_WIDTH  (V_SYNCH_WIDTH),
        .BACK_PORCH  (V_BACK_PORCH)
    ) u_v_timer (
        .clk    (i_clk_pxl),
        .rst    (i_reset),
        .en     (h_wrap),
        .pos    (o_sy),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) begin
            fc <= '0;
        end else if (v_wrap) begin
            if (fc == FC_LAST) begin
                fc <= '0;
            end else begin
                fc <= fc + 1'b1;
            end
        end
    end

    assign o_fc    = fc;
    assign o_hsync = h_sync;
    assign o_vsync = v_sync;
    assign o_de    = h_active && v_active;
    assign o_nf    = (o_sx == '0) && (o_sy == '0);

endmodule

// File: tb/tb_video_signal_generator.sv
// ---------------------------------------------------------------------------
// tb_video_signal_generator
//
// Two instances share one pixel clock:
//   u_small  reduced timing (8/2/2/2 pixels, 4/1/1/1 lines, FPS 3): a driver
//            issues random resets and pushes the expected output of every
//            half cycle into exp_q; a monitor pops and compares.
//   u_big    default 720p timing: reset mid-line at sx=500, then two full
//            lines plus the start of a third, compared cycle by cycle.
// Expected values come from a reference that counts pixels since reset and
// derives position, frame number and all decodes with division/modulo.
// ---------------------------------------------------------------------------
module tb_video_signal_generator;

    // Reduced timing
    localparam int S_AH = 8,  S_HFP = 2, S_HSW = 2, S_HBP = 2;
    localparam int S_AV = 4,  S_VFP = 1, S_VSW = 1, S_VBP = 1;
    localparam int S_FPS = 3;
    localparam int S_TH = S_AH + S_HFP + S_HSW + S_HBP;   // 14
    localparam int S_TV = S_AV + S_VFP + S_VSW + S_VBP;   // 7

    // Default 720p timing
    localparam int B_AH = 1280, B_HFP = 110, B_HSW = 40, B_HBP = 220;
    localparam int B_AV = 720,  B_VFP = 5,   B_VSW = 5,  B_VBP = 20;
    localparam int B_FPS = 60;
    localparam int B_TH = B_AH + B_HFP + B_HSW + B_HBP;   // 1650
    localparam int B_TV = B_AV + B_VFP + B_VSW + B_VBP;   // 750

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_s;
    logic rst_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    logic [3:0]  s_sx;
    logic [2:0]  s_sy;
    logic        s_hsync, s_vsync, s_de, s_nf;
    logic [1:0]  s_fc;

    logic [10:0] b_sx;
    logic [9:0]  b_sy;
    logic        b_hsync, b_vsync, b_de, b_nf;
    logic [5:0]  b_fc;

    video_signal_generator #(
        .ACTIVE_H_PIXELS (S_AH), .H_FRONT_PORCH (S_HFP),
        .H_SYNCH_WIDTH   (S_HSW), .H_BACK_PORCH (S_HBP),
        .ACTIVE_LINES    (S_AV), .V_FRONT_PORCH (S_VFP),
        .V_SYNCH_WIDTH   (S_VSW), .V_BACK_PORCH (S_VBP),
        .FPS             (S_FPS)
    ) u_small (
        .i_clk_pxl (clk),
        .i_reset   (rst_s),
        .o_sx      (s_sx),
        .o_sy      (s_sy),
        .o_hsync   (s_hsync),
        .o_vsync   (s_vsync),
        .o_de      (s_de),
        .o_nf      (s_nf),
        .o_fc      (s_fc)
    );

    video_signal_generator u_big (
        .i_clk_pxl (clk),
        .i_reset   (rst_b),
        .o_sx      (b_sx),
        .o_sy      (b_sy),
        .o_hsync   (b_hsync),
        .o_vsync   (b_vsync),
        .o_de      (b_de),
        .o_nf      (b_nf),
        .o_fc      (b_fc)
    );

    // ---------------- reference model ----------------
    // n = pixel clocks elapsed since counting restarted at (0,0).
    function automatic logic [12:0] model_small(input int n);
        int sx, sy, fc;
        logic hs, vs, de, nf;
        sx = n % S_TH;
        sy = (n / S_TH) % S_TV;
        fc = (n / (S_TH * S_TV)) % S_FPS;
        de = (sx < S_AH) && (sy < S_AV);
        hs = (sx >= S_AH + S_HFP) && (sx < S_AH + S_HFP + S_HSW);
        vs = (sy >= S_AV + S_VFP) && (sy < S_AV + S_VFP + S_VSW);
        nf = (sx == 0) && (sy == 0);
        return {2'(fc), nf, de, vs, hs, 3'(sy), 4'(sx)};
    endfunction

    function automatic logic [30:0] model_big(input int n);
        int sx, sy, fc;
        logic hs, vs, de, nf;
        sx = n % B_TH;
        sy = (n / B_TH) % B_TV;
        fc = (n / (B_TH * B_TV)) % B_FPS;
        de = (sx < B_AH) && (sy < B_AV);
        hs = (sx >= B_AH + B_HFP) && (sx < B_AH + B_HFP + B_HSW);
        vs = (sy >= B_AV + B_VFP) && (sy < B_AV + B_VFP + B_VSW);
        nf = (sx == 0) && (sy == 0);
        return {6'(fc), nf, de, vs, hs, 10'(sy), 11'(sx)};
    endfunction

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];
    logic        sb_run = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic sb_compare();
        logic [12:0] act;
        act = {s_fc, s_nf, s_de, s_vsync, s_hsync, s_sy, s_sx};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow at %0t: got %h with no expectation queued", $time, act);
        end else begin
            check("sb_small", 32'(act), 32'(exp_q.pop_front()));
        end
    endtask

    // Monitor: outputs are always valid, so sample every half cycle,
    // #1 after each edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (sb_run) sb_compare();
            @(posedge clk);
            #1;
            if (sb_run) sb_compare();
        end
    end

    task automatic check_big(input string name, input int n);
        logic [30:0] act;
        act = {b_fc, b_nf, b_de, b_vsync, b_hsync, b_sy, b_sx};
        check(name, 32'(act), 32'(model_big(n)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   n_s;
        int   n_b;
        int   rst_left;
        logic r;

        rst_s    = 1'b1;
        rst_b    = 1'b1;
        n_s      = 0;
        n_b      = 0;
        rst_left = 0;

        // Phase 1: reduced timing, random resets after a long clean run
        // (700 cycles covers 7 frames, two fc wraps).
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin
                r = 1'b1;
            end else if (rst_left > 0) begin
                r = 1'b1;
                rst_left--;
            end else if (cyc > 700 && $urandom_range(0, 299) == 0) begin
                r = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                r = 1'b0;
            end
            rst_s = r;
            // Half cycle after the falling edge: reset acts at once.
            if (r) n_s = 0;
            exp_q.push_back(model_small(n_s));
            // After the next rising edge.
            if (r) n_s = 0;
            else   n_s++;
            exp_q.push_back(model_small(n_s));
        end
        @(posedge clk);
        #2;
        sb_run = 1'b0;
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // Phase 2: default timing.
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_b = 0;
        check_big("big_release", n_b);
        repeat (500) begin
            @(posedge clk);
            #1;
            n_b++;
            check_big("big_run_pre", n_b);
        end
        // Mid-line reset at sx=500, asserted away from any clock edge.
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        n_b = 0;
        check_big("big_async_reset", n_b);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_big("big_reset_hold", n_b);
        end
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check_big("big_release2", n_b);
        repeat (2 * B_TH + 100) begin
            @(posedge clk);
            #1;
            n_b++;
            check_big("big_run", n_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
